// File: rtl/wash_cycle_sequencer_pkg.sv
// Shared types and helpers for the wash-cycle sequencer.
// Phase limits are seconds x ticks x multiplier, never zero.
package wash_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4
    } wash_state_t;

    function automatic logic [3:0] mult_of(input logic [1:0] sel);
        logic [3:0] m;
        unique case (sel)
            2'd0:    m = 4'd1;
            2'd1:    m = 4'd2;
            2'd2:    m = 4'd4;
            default: m = 4'd8;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] phase_limit(
        input logic [31:0] sec,
        input logic [31:0] ticks,
        input logic [3:0]  mult
    );
        logic [31:0] p;
        p = sec * ticks * {28'd0, mult};
        return (p == 32'd0) ? 32'd1 : p;
    endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// Control inputs and status outputs of the wash-cycle sequencer.
// master drives the controls, slave is the sequencer.
interface wash_cycle_sequencer_if;
    logic        coin_in;
    logic        double_wash;
    logic        timer_pause;
    logic [1:0]  clk_freq_sel;
    logic        busy;
    logic [2:0]  phase;
    logic        water_valve;
    logic        agitate;
    logic        spin_motor;
    logic        wash_done;
    logic [31:0] phase_count;

    modport master (
        output coin_in, double_wash, timer_pause, clk_freq_sel,
        input  busy, phase, water_valve, agitate,
        input  spin_motor, wash_done, phase_count
    );

    modport slave (
        input  coin_in, double_wash, timer_pause, clk_freq_sel,
        output busy, phase, water_valve, agitate,
        output spin_motor, wash_done, phase_count
    );
endinterface

// File: rtl/wash_cycle_sequencer_phase_timer.sv
// Per-phase cycle counter; done flags the last cycle of a phase.
module phase_timer (
    input  logic        clk,
    input  logic        Counter_RST,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limit,
    output logic [31:0] count,
    output logic        done
);

    always_ff @(posedge clk or negedge Counter_RST) begin
        if (!Counter_RST)
            count <= 32'd0;
        else if (clr)
            count <= 32'd0;
        else if (en)
            count <= count + 32'd1;
    end

    assign done = en && (count == limit - 32'd1);

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle sequencer: coin -> FILL/WASH/RINSE/SPIN -> IDLE.
// Optional second wash+rinse pass; timer frozen only by pause in SPIN.
module wash_cycle_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned FILL_SEC      = 120,
    parameter int unsigned WASH_SEC      = 300,
    parameter int unsigned RINSE_SEC     = 120,
    parameter int unsigned SPIN_SEC      = 60
) (
    input  logic                   clk,
    input  logic                   Counter_RST,
    wash_cycle_sequencer_if.slave  bus
);

    wash_state_t state_q, state_d;
    logic        dw_q, second_q, second_set;
    logic [3:0]  mult_q;
    logic [31:0] limit, count;
    logic        en, clr, done, accept;
    logic        busy_q, valve_q, agit_q, spin_q, done_q;

    assign accept = (state_q == IDLE) && bus.coin_in;
    assign en     = (state_q != IDLE) &&
                    !((state_q == SPIN) && bus.timer_pause);
    assign clr    = (state_q == IDLE) || done;

    always_comb begin
        limit = 32'd1;
        unique case (state_q)
            FILL:    limit = phase_limit(FILL_SEC, TICKS_PER_SEC, mult_q);
            WASH:    limit = phase_limit(WASH_SEC, TICKS_PER_SEC, mult_q);
            RINSE:   limit = phase_limit(RINSE_SEC, TICKS_PER_SEC, mult_q);
            SPIN:    limit = phase_limit(SPIN_SEC, TICKS_PER_SEC, mult_q);
            default: limit = 32'd1;
        endcase
    end

    phase_timer u_timer (
        .clk         (clk),
        .Counter_RST (Counter_RST),
        .clr         (clr),
        .en          (en),
        .limit       (limit),
        .count       (count),
        .done        (done)
    );

    always_comb begin
        state_d    = state_q;
        second_set = 1'b0;
        unique case (state_q)
            IDLE:  if (bus.coin_in) state_d = FILL;
            FILL:  if (done) state_d = WASH;
            WASH:  if (done) state_d = RINSE;
            RINSE: begin
                if (done) begin
                    if (dw_q && !second_q) begin
                        state_d    = WASH;
                        second_set = 1'b1;
                    end else begin
                        state_d = SPIN;
                    end
                end
            end
            SPIN:    if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Counter_RST) begin
        if (!Counter_RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Options are captured once per coin and held for the whole cycle
    always_ff @(posedge clk or negedge Counter_RST) begin
        if (!Counter_RST) begin
            dw_q     <= 1'b0;
            mult_q   <= 4'd0;
            second_q <= 1'b0;
        end else if (accept) begin
            dw_q     <= bus.double_wash;
            mult_q   <= mult_of(bus.clk_freq_sel);
            second_q <= 1'b0;
        end else if (second_set) begin
            second_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Counter_RST) begin
        if (!Counter_RST) begin
            busy_q  <= 1'b0;
            valve_q <= 1'b0;
            agit_q  <= 1'b0;
            spin_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            busy_q  <= state_d != IDLE;
            valve_q <= (state_d == FILL) || (state_d == RINSE);
            agit_q  <= (state_d == WASH) || (state_d == RINSE);
            spin_q  <= state_d == SPIN;
            done_q  <= (state_q == SPIN) && (state_d == IDLE);
        end
    end

    assign bus.busy        = busy_q;
    assign bus.phase       = state_q;
    assign bus.water_valve = valve_q;
    assign bus.agitate     = agit_q;
    // Pause cuts the motor in the same cycle it is raised
    assign bus.spin_motor  = spin_q && !bus.timer_pause;
    assign bus.wash_done   = done_q;
    assign bus.phase_count = count;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer with short phase durations.
module tb_wash_cycle_sequencer;

    logic clk = 1'b0;
    logic Counter_RST = 1'b0;
    int   checks = 0;
    int   failures = 0;

    wash_cycle_sequencer_if bus();

    wash_cycle_sequencer #(
        .TICKS_PER_SEC (1),
        .FILL_SEC      (3),
        .WASH_SEC      (5),
        .RINSE_SEC     (3),
        .SPIN_SEC      (2)
    ) dut (
        .clk         (clk),
        .Counter_RST (Counter_RST),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Expected schedule: phase code, length in cycles, paused flag
    int sch_ph[8];
    int sch_len[8];
    bit sch_hold[8];
    int sch_n;

    task automatic sched_clear();
        sch_n = 0;
    endtask

    task automatic sched_add(input int ph, input int len, input bit hold);
        sch_ph[sch_n]   = ph;
        sch_len[sch_n]  = len;
        sch_hold[sch_n] = hold;
        sch_n++;
    endtask

    // {busy, phase, valve, agitate, spin, done, count} for cycle k
    function automatic logic [39:0] exp_vec(input int k);
        int t;
        logic [2:0] ph;
        logic [31:0] c;
        logic hd, dn;
        t = 1; ph = 3'd0; c = 32'd0; hd = 1'b0;
        for (int i = 0; i < sch_n; i++) begin
            if (ph == 3'd0 && k >= t && k < t + sch_len[i]) begin
                ph = 3'(sch_ph[i]);
                hd = sch_hold[i];
                c  = hd ? 32'd0 : 32'(k - t);
            end
            t += sch_len[i];
        end
        dn = (k == t);
        return {ph != 3'd0, ph, ph == 3'd1 || ph == 3'd3,
                ph == 3'd2 || ph == 3'd3, ph == 3'd4 && !hd, dn, c};
    endfunction

    function automatic logic [39:0] obs_vec();
        return {bus.busy, bus.phase, bus.water_valve, bus.agitate,
                bus.spin_motor, bus.wash_done, bus.phase_count};
    endfunction

    task automatic sched_normal();
        sched_clear();
        sched_add(1, 3, 0);
        sched_add(2, 5, 0);
        sched_add(3, 3, 0);
        sched_add(4, 2, 0);
    endtask

    task automatic start_coin(input logic dw, input logic [1:0] sel);
        @(negedge clk);
        bus.coin_in      = 1'b1;
        bus.double_wash  = dw;
        bus.clk_freq_sel = sel;
        bus.timer_pause  = 1'b0;
    endtask

    task automatic test_reset();
        logic [39:0] o;
        Counter_RST      = 1'b0;
        bus.coin_in      = 1'b0;
        bus.double_wash  = 1'b0;
        bus.timer_pause  = 1'b0;
        bus.clk_freq_sel = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        o = obs_vec();
        checks++;
        if (o !== 40'd0) begin
            failures++;
            $display("FAIL reset_state got %h want 0", o);
        end
        Counter_RST = 1'b1;
        repeat (2) @(negedge clk);
        o = obs_vec();
        checks++;
        if (o !== 40'd0) begin
            failures++;
            $display("FAIL idle_after_reset got %h want 0", o);
        end
    endtask

    task automatic test_normal();
        logic [39:0] o, e;
        sched_normal();
        start_coin(1'b0, 2'd0);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1 bus.coin_in = (k == 2) || (k == 10);
            @(negedge clk);
            o = obs_vec();
            e = exp_vec(k);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL normal c%0d got %h want %h", k, o, e);
            end
        end
        bus.coin_in = 1'b0;
    endtask

    task automatic test_double();
        logic [39:0] o, e;
        sched_clear();
        sched_add(1, 3, 0);
        sched_add(2, 5, 0);
        sched_add(3, 3, 0);
        sched_add(2, 5, 0);
        sched_add(3, 3, 0);
        sched_add(4, 2, 0);
        start_coin(1'b1, 2'd0);
        for (int k = 1; k <= 23; k++) begin
            @(posedge clk);
            #1 bus.coin_in = 1'b0;
            bus.double_wash = 1'b0;
            @(negedge clk);
            o = obs_vec();
            e = exp_vec(k);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL double c%0d got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_scaling();
        logic [39:0] o, e;
        sched_clear();
        sched_add(1, 24, 0);
        sched_add(2, 40, 0);
        sched_add(3, 24, 0);
        sched_add(4, 16, 0);
        start_coin(1'b0, 2'd3);
        for (int k = 1; k <= 106; k++) begin
            @(posedge clk);
            #1 bus.coin_in = 1'b0;
            if (k == 5) bus.clk_freq_sel = 2'd0;
            @(negedge clk);
            o = obs_vec();
            e = exp_vec(k);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL scaling c%0d got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_pause_spin();
        logic [39:0] o, e;
        sched_clear();
        sched_add(1, 3, 0);
        sched_add(2, 5, 0);
        sched_add(3, 3, 0);
        sched_add(4, 4, 1);
        sched_add(4, 2, 0);
        start_coin(1'b0, 2'd0);
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            #1 bus.coin_in = 1'b0;
            bus.timer_pause = (k >= 12) && (k <= 15);
            @(negedge clk);
            o = obs_vec();
            e = exp_vec(k);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pause_spin c%0d got %h want %h", k, o, e);
            end
        end
        bus.timer_pause = 1'b0;
    endtask

    task automatic test_pause_wash();
        logic [39:0] o, e;
        sched_normal();
        start_coin(1'b0, 2'd0);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1 bus.coin_in = 1'b0;
            bus.timer_pause = (k >= 5) && (k <= 8);
            @(negedge clk);
            o = obs_vec();
            e = exp_vec(k);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL pause_wash c%0d got %h want %h", k, o, e);
            end
        end
        bus.timer_pause = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [39:0] o, e;
        sched_normal();
        start_coin(1'b0, 2'd0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1 bus.coin_in = 1'b0;
            @(negedge clk);
        end
        o = obs_vec();
        e = exp_vec(6);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL pre_reset_wash got %h want %h", o, e);
        end
        Counter_RST = 1'b0;
        #1 o = obs_vec();
        checks++;
        if (o !== 40'd0) begin
            failures++;
            $display("FAIL mid_reset got %h want 0", o);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        Counter_RST = 1'b1;
        repeat (2) @(negedge clk);
        o = obs_vec();
        checks++;
        if (o !== 40'd0) begin
            failures++;
            $display("FAIL post_reset_idle got %h want 0", o);
        end
        start_coin(1'b0, 2'd0);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            #1 bus.coin_in = 1'b0;
            @(negedge clk);
            o = obs_vec();
            e = exp_vec(k);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL restart c%0d got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [39:0] o, e;
        sched_normal();
        start_coin(1'b0, 2'd0);
        for (int k = 1; k <= 29; k++) begin
            @(posedge clk);
            #1 bus.coin_in = (k == 14);
            @(negedge clk);
            o = obs_vec();
            e = (k <= 14) ? exp_vec(k) : exp_vec(k - 14);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back c%0d got %h want %h", k, o, e);
            end
        end
        bus.coin_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_double();
        test_scaling();
        test_pause_spin();
        test_pause_wash();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
Top-level sequencer for the washing-machine controller. It accepts a coin, then steps through FILL, WASH, RINSE and SPIN, optionally repeating one wash-and-rinse pass for double wash. An internal phase timer sets each phase length from per-phase durations in seconds, scaled by the selected clock frequency. It drives the valve and motor enables and pulses a completion flag when the cycle ends.

Parameters:
TICKS_PER_SEC, 1, clk cycles per second at frequency multiplier 1
FILL_SEC, 120, filling duration in seconds
WASH_SEC, 300, washing duration in seconds
RINSE_SEC, 120, rinsing duration in seconds
SPIN_SEC, 60, spinning duration in seconds

Ports:
clk  input  1  system clock
Counter_RST  input  1  reset, asynchronous, active-low
coin_in  input  1  coin accepted pulse; sampled only in IDLE
double_wash  input  1  request extra wash+rinse pass; latched with coin
timer_pause  input  1  freezes phase timer, effective in SPIN only
clk_freq_sel  input  2  frequency multiplier select: 0→1, 1→2, 2→4, 3→8; latched with coin
busy  output  1  high in any non-IDLE state
phase  output  3  state code: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4
water_valve  output  1  high in FILL and RINSE
agitate  output  1  high in WASH and RINSE
spin_motor  output  1  high in SPIN while not paused
wash_done  output  1  one-cycle pulse on return to IDLE
phase_count  output  32  elapsed cycles in current phase, 0-based

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0, including phase_count. Latched double_wash, latched multiplier and the second-pass flag all cleared.
- Phase limit L = SEC × TICKS_PER_SEC × mult, computed in 32 bits modulo 2^32. L = 0 is treated as 1.
- IDLE:
  - coin_in=1 at edge N → FILL from cycle N+1, phase_count=0.
  - double_wash and clk_freq_sel are latched on the same edge.
- Timer:
  - phase_count increments by 1 each cycle in an active state.
  - When phase_count == L-1 and not frozen, the next edge clears it to 0 and advances state. Each unpaused phase therefore lasts exactly L cycles.
- Transitions:
  - FILL → WASH → RINSE.
  - RINSE → WASH if double_wash was latched and the second pass has not run; the second-pass flag is set on that transition. Otherwise RINSE → SPIN.
  - SPIN → IDLE.
- Pause:
  - timer_pause=1 in SPIN holds phase_count and state, and forces spin_motor=0.
  - Pause held on the terminal count delays the exit until it is released.
  - timer_pause is ignored in all other states.
- Outputs are registered, decoded from the next state, and change on the same edge as phase.
- wash_done=1 for exactly the first IDLE cycle after SPIN completes.
  - A coin in that cycle is accepted: FILL next cycle, wash_done falls.
- coin_in, double_wash and clk_freq_sel changes while busy are ignored. No queuing of coins.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no wash_done pulse.

Decomposition:
- Package wash_pkg holds:
  - state enum (codes as above)
  - multiplier function mult_of(sel)
  - phase-limit function (SEC, TICKS, mult → 32-bit, zero clamped to 1)
- Sub-module phase_timer, with ports:
  - clk, Counter_RST
  - clr, en, limit[31:0]
  - count[31:0]
  - done (combinational: count == limit-1 && en)
- The FSM, input latches and output decode live in the top.

Test Plan:
All scenarios use TICKS_PER_SEC=1, FILL_SEC=3, WASH_SEC=5, RINSE_SEC=3, SPIN_SEC=2, sel=0. Coin is sampled at edge 0; cycle k means the interval after edge k.
1. Normal cycle, coin pulse at edge 0 → FILL cycles 1–3, WASH 4–8, RINSE 9–11, SPIN 12–13, IDLE at 14 with wash_done=1 only in cycle 14. water_valve high 1–3 and 9–11.
2. Double wash, double_wash=1 with coin → WASH 4–8, RINSE 9–11, WASH 12–16, RINSE 17–19, SPIN 20–21, wash_done in cycle 22.
3. Scaling, clk_freq_sel=3 with coin, then changed to 0 mid-FILL → FILL lasts 24 cycles, WASH 40; latched value kept.
4. Pause:
   - timer_pause=1 for 4 cycles starting cycle 12 → phase_count holds 0, spin_motor=0 during pause, wash_done in cycle 18.
   - Same pause applied during WASH has no effect.
5. Reset and coin handling:
   - Counter_RST low in cycle 6 (WASH) → all outputs 0 immediately; after release, coin restarts at FILL with phase_count=0.
   - Coin pulses in cycles 2 and 10 are ignored.
6. Back-to-back, coin in wash_done cycle 14 → FILL cycles 15–17; wash_done low from cycle 15.
